buffer: RTL and testbench
=========================

# buffer

Page data buffer for the NAND flash controller: a synchronous circular FIFO that stages one page of byte data between the host-side interface and the flash-side sequencer. Accepts writes and reads on one clock, reports occupancy, and flags overflow/underflow. Sits between the host data path and the flash I/O engine, and is driven through the buffer interface bundle.

## Interface
- `DATA_W`, 8: data word width (bits).
- `DEPTH`, 2048: number of entries, one NAND page; must be a power of two.
- `ADDR_W`, 11: pointer width, equal to log2(`DEPTH`).
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `clr`  in  1  synchronous clear: empties the buffer and clears flags.
- `wr_en`  in  1  write request.
- `din`  in  DATA_W  write data.
- `rd_en`  in  1  read request.
- `dout`  out  DATA_W  registered read data.
- `dout_valid`  out  1  high for one cycle when `dout` carries a new word.
- `count`  out  ADDR_W+1  number of stored words, 0..DEPTH.
- `empty`  out  1  high when `count` is 0.
- `full`  out  1  high when `count` equals DEPTH.
- `ovf`  out  1  sticky: a write was attempted while full.
- `udf`  out  1  sticky: a read was attempted while empty.
- `par_err`  out  1  parity mismatch on the word in `dout`; only present with `BUFFER_PARITY_EN`.

## Operation
- Storage: DEPTH x DATA_W array, plus write pointer `wp`, read pointer `rp` (ADDR_W bits each), and an occupancy counter.
- Write: when `wr_en` is high and the buffer is not full, `mem[wp] <= din`, `wp` increments, and `count` increments.
- Write while full: the data is dropped, pointers and `count` are unchanged, and `ovf` sets.
- Read: when `rd_en` is high and the buffer is not empty, `dout <= mem[rp]`, `dout_valid` goes high on the next cycle, `rp` increments, and `count` decrements.
- Read while empty: `dout` holds its value, `dout_valid` stays 0, and `udf` sets.
- Simultaneous write and read when neither is blocked: both proceed and `count` is unchanged.
- Simultaneous write and read when full: the read proceeds, and the write is blocked and sets `ovf`. Full/empty are evaluated on the pre-edge state.
- Simultaneous write and read when empty: the write proceeds, and the read is blocked and sets `udf`. There is no write-through.
- Pointers wrap modulo DEPTH, from DEPTH-1 to 0.
- `clr` has priority over `wr_en` and `rd_en` in the same cycle. It zeroes `wp`, `rp` and `count`, clears `ovf`, `udf`, `dout_valid` and `par_err`, and leaves `dout` and the memory contents unchanged.
- `ovf` and `udf` clear only on reset or `clr`.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `count`=0, `empty`=1, `full`=0, `ovf`=0, `udf`=0, `par_err`=0. Pointers are 0; memory contents are not reset.
- Reset asserted mid-operation discards all content immediately and asynchronously.
- Read latency: 1 cycle from the `rd_en` sample edge to `dout`/`dout_valid`.
- `count`, `empty`, `full`, `ovf` and `udf` are registered and update on the same edge as the operation.
- Back-to-back reads are possible at 1 word/cycle; back-to-back writes are possible at 1 word/cycle.

## Configuration
- `BUFFER_PARITY_EN`: defined: each entry stores an extra even-parity bit computed from `din` at write time. On read, `par_err` is registered alongside `dout` and is high for that word if the stored parity mismatches. The bench may flip the stored parity bit by hierarchical force to check this path.
- Not defined: no parity storage, and `par_err` is tied to 0.

## Test plan
- Reset, then idle: `empty`=1, `full`=0, `count`=0, `dout`=0, `dout_valid`=0, `ovf`=0, `udf`=0.
- Write 0x00..0xFF then 0x00..0xFF again until 2048 words are written -> `full`=1, `count`=2048. Read 2048 words -> data returned in order, `dout_valid` each cycle one cycle after `rd_en`, ending with `empty`=1.
- When full, write 0xAA -> `ovf`=1 and `count` stays 2048. First read returns 0x00, not 0xAA.
- When empty, read -> `udf`=1 and `dout_valid`=0. Then `clr` -> `udf`=0 and `ovf`=0.
- With 5 words stored, drive `wr_en`=`rd_en`=1 with `din`=0x5C for 3 cycles -> `count` stays 5 and the oldest 3 words are output. Repeat across the DEPTH-1 -> 0 pointer wrap with identical results.
- With 10 words stored, assert `clr` together with `wr_en` -> `count`=0, `empty`=1, and the write is discarded. Separately, assert `rst_n`=0 mid-stream -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/buffer.sv
// Page data buffer: circular FIFO staging one NAND page between host and flash engine.
// Optional macro BUFFER_PARITY_EN adds a stored even-parity bit per entry and drives par_err.
module buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              udf,
    output logic              par_err
);

`ifdef BUFFER_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    logic [MEM_W-1:0]  mem [DEPTH];
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;

    logic [ADDR_W-1:0] wp_reg;
    logic [ADDR_W-1:0] rp_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   count_next;
    logic [DATA_W-1:0] dout_reg;
    logic              dout_valid_reg;
    logic              empty_reg;
    logic              full_reg;
    logic              ovf_reg;
    logic              udf_reg;
    logic              wr_ok;
    logic              rd_ok;

    // Blocking decisions use the pre-edge full/empty, so a full buffer still reads and an empty one still writes.
    assign wr_ok = wr_en && !full_reg;
    assign rd_ok = rd_en && !empty_reg;

`ifdef BUFFER_PARITY_EN
    assign wr_word = {^din, din};
`else
    assign wr_word = din;
`endif

    assign rd_word = mem[rp_reg];

    always_comb begin
        count_next = count_reg;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Storage is deliberately not reset so it maps onto block RAM; clr discards the write.
    always_ff @(posedge clk) begin
        if (wr_ok && !clr) begin
            mem[wp_reg] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_reg         <= '0;
            rp_reg         <= '0;
            count_reg      <= '0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            empty_reg      <= 1'b1;
            full_reg       <= 1'b0;
            ovf_reg        <= 1'b0;
            udf_reg        <= 1'b0;
        end else if (clr) begin
            wp_reg         <= '0;
            rp_reg         <= '0;
            count_reg      <= '0;
            dout_valid_reg <= 1'b0;
            empty_reg      <= 1'b1;
            full_reg       <= 1'b0;
            ovf_reg        <= 1'b0;
            udf_reg        <= 1'b0;
        end else begin
            if (wr_ok) begin
                wp_reg <= wp_reg + PTR_ONE;
            end
            if (rd_ok) begin
                rp_reg   <= rp_reg + PTR_ONE;
                dout_reg <= rd_word[DATA_W-1:0];
            end
            dout_valid_reg <= rd_ok;
            count_reg      <= count_next;
            empty_reg      <= (count_next == '0);
            full_reg       <= (count_next == FULL_COUNT);
            if (wr_en && full_reg) begin
                ovf_reg <= 1'b1;
            end
            if (rd_en && empty_reg) begin
                udf_reg <= 1'b1;
            end
        end
    end

`ifdef BUFFER_PARITY_EN
    logic par_err_reg;

    // An even-parity entry XORs to zero across data and parity bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_reg <= 1'b0;
        end else if (clr) begin
            par_err_reg <= 1'b0;
        end else if (rd_ok) begin
            par_err_reg <= ^rd_word;
        end
    end

    assign par_err = par_err_reg;
`else
    assign par_err = 1'b0;
`endif

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign count      = count_reg;
    assign empty      = empty_reg;
    assign full       = full_reg;
    assign ovf        = ovf_reg;
    assign udf        = udf_reg;

endmodule

// File: tb/tb_buffer.sv
// Self-checking bench for buffer: vector table, directed page/wrap/clear/reset sequences,
// and random traffic compared against a queue-based reference model.
module tb_buffer;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2048;
    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              wr_en;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              ovf;
    logic              udf;
    logic              par_err;

    buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .din(din),
        .rd_en(rd_en), .dout(dout), .dout_valid(dout_valid), .count(count),
        .empty(empty), .full(full), .ovf(ovf), .udf(udf), .par_err(par_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the FIFO contents as a queue plus the visible flags.
    logic [7:0] q[$];
    logic [7:0] m_dout;
    bit         m_dv;
    bit         m_ovf;
    bit         m_udf;

    typedef struct {
        bit         c;
        bit         w;
        bit         r;
        logic [7:0] d;
        int         cnt;
        bit         emp;
        bit         ful;
        bit         ovf;
        bit         udf;
        bit         dv;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = 8'h00;
        m_dv   = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic model_update(input bit c, input bit w, input bit r, input logic [7:0] d);
        bit was_full;
        bit was_empty;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_dv  = 1'b0;
        end else begin
            if (w && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_udf = 1'b1;
            m_dv = 1'b0;
            if (r && !was_empty) begin
                m_dout = q.pop_front();
                m_dv   = 1'b1;
            end
            if (w && !was_full) q.push_back(d);
        end
    endtask

    task automatic check_model();
        chk("m_count", 32'(count), 32'(q.size()));
        chk("m_empty", 32'(empty), 32'(q.size() == 0));
        chk("m_full",  32'(full),  32'(q.size() == DEPTH));
        chk("m_ovf",   32'(ovf),   32'(m_ovf));
        chk("m_udf",   32'(udf),   32'(m_udf));
        chk("m_dv",    32'(dout_valid), 32'(m_dv));
        chk("m_dout",  32'(dout),  32'(m_dout));
        chk("m_par",   32'(par_err), 32'd0);
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at that same point.
    task automatic step(input bit c, input bit w, input bit r, input logic [7:0] d);
        clr   = c;
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        #1;
        model_update(c, w, r, d);
        check_model();
        clr   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic simul_seq(input string tag);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 8'(8'hA0 + k));
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b1, 8'h5C);
            chk({tag, "_count"}, 32'(count), 32'd5);
            chk({tag, "_dout"},  32'(dout),  32'(8'hA0 + k));
            chk({tag, "_dv"},    32'(dout_valid), 32'd1);
        end
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 8'h00);
        chk({tag, "_tail"}, 32'(dout), 32'h5C);
        $display("seq %s: simultaneous wr/rd with 5 stored done", tag);
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 8'h33, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 8'h44, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 8'h55, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55};

        rst_n = 1'b0;
        clr   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_dout",  32'(dout),  32'd0);
        chk("rst_dv",    32'(dout_valid), 32'd0);
        chk("rst_ovf",   32'(ovf),   32'd0);
        chk("rst_udf",   32'(udf),   32'd0);
        $display("seq reset: idle state checked");

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].c, tbl[i].w, tbl[i].r, tbl[i].d);
            chk("t_count", 32'(count), 32'(tbl[i].cnt));
            chk("t_empty", 32'(empty), 32'(tbl[i].emp));
            chk("t_full",  32'(full),  32'(tbl[i].ful));
            chk("t_ovf",   32'(ovf),   32'(tbl[i].ovf));
            chk("t_udf",   32'(udf),   32'(tbl[i].udf));
            chk("t_dv",    32'(dout_valid), 32'(tbl[i].dv));
            chk("t_dout",  32'(dout),  32'(tbl[i].dout));
            $display("vec %0d: clr=%0b wr=%0b rd=%0b din=%02h -> count=%0d dv=%0b dout=%02h",
                     i, tbl[i].c, tbl[i].w, tbl[i].r, tbl[i].d, count, dout_valid, dout);
        end

        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_count", 32'(count), 32'd2048);
        step(1'b0, 1'b1, 1'b0, 8'hAA);
        chk("ovf_set",   32'(ovf),   32'd1);
        chk("ovf_count", 32'(count), 32'd2048);
        $display("seq fill: %0d words written, overflow write attempted", DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk("drain_dout", 32'(dout), 32'(i % 256));
            chk("drain_dv",   32'(dout_valid), 32'd1);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("udf_set", 32'(udf), 32'd1);
        chk("udf_dv",  32'(dout_valid), 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("clr_udf", 32'(udf), 32'd0);
        chk("clr_ovf", 32'(ovf), 32'd0);
        $display("seq drain: page read back, underflow and clear checked");

        simul_seq("simul");
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH - 2; i++) step(1'b0, 1'b1, 1'b0, 8'(i * 7));
        for (int i = 0; i < DEPTH - 2; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        simul_seq("wrap");

        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
        step(1'b1, 1'b1, 1'b0, 8'h77);
        chk("clrwr_count", 32'(count), 32'd0);
        chk("clrwr_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("clrwr_discard_dv",  32'(dout_valid), 32'd0);
        chk("clrwr_discard_udf", 32'(udf), 32'd1);
        $display("seq clr+wr: write discarded by clear");

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom));
        end
        $display("seq random: 3000 cycles against reference model, count=%0d", count);

        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h3C + i));
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'hC3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_full",  32'(full),  32'd0);
        chk("arst_dout",  32'(dout),  32'd0);
        chk("arst_dv",    32'(dout_valid), 32'd0);
        chk("arst_ovf",   32'(ovf),   32'd0);
        chk("arst_udf",   32'(udf),   32'd0);
        chk("arst_par",   32'(par_err), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h9D);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("post_rst_dout", 32'(dout), 32'h9D);
        $display("seq async reset: mid-stream reset and recovery checked");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
